alarm_controller: RTL

ALARM_CONTROLLER -- requirements
Module: alarm_controller

---
 rtl/alarm_controller.sv | 138 +++++++++++++
 1 files changed

// File: rtl/alarm_controller.sv
// Alarm controller: arms on alarm_en, rings at the stored hh:mm:00, optional snooze (define ALARM_SNOOZE_EN).
// Latency: status outputs are registered one cycle after the causing event; reset is async, active-low.
module alarm_controller #(
    parameter int SNOOZE_MIN     = 5,
    parameter int RING_TIMEOUT_S = 60,
    parameter int BEEP_DIV       = 50000
) (
    input  logic       CLK100MHZ,
    input  logic       CPU_RESETN,
    input  logic [2:0] state,
    input  logic [5:0] seconds,
    input  logic [5:0] minutes,
    input  logic [4:0] hours,
    input  logic [5:0] inalarm_minutes,
    input  logic [4:0] inalarm_hours,
    input  logic       alarm_en,
    input  logic       stop_btn,
    input  logic       snooze_btn,
    output logic [5:0] alarm_minutes,
    output logic [4:0] alarm_hours,
    output logic       ringing,
    output logic       snooze_active,
    output logic       buzzer
);
    localparam logic [2:0] SET_TIME  = 3'b010;
    localparam logic [2:0] SET_ALARM = 3'b011;
    localparam int DIV_W = (BEEP_DIV > 1) ? $clog2(BEEP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BEEP_DIV - 1);
    localparam logic [7:0] RING_LOAD = 8'(RING_TIMEOUT_S);
    localparam logic [11:0] SNZ_LOAD = 12'(SNOOZE_MIN * 60);

    typedef enum logic [1:0] {IDLE, ARMED, RINGING, SNOOZE} fsm_t;

    fsm_t             fsm, fsm_nxt;
    logic [5:0]       sec_prev;
    logic             stop_prev;
    logic [7:0]       ring_cnt;
    logic [DIV_W-1:0] div;
    logic             sec_tick, stop_edge, snooze_edge, match;

    assign sec_tick  = (seconds != sec_prev) && (state != SET_TIME);
    assign stop_edge = stop_btn & ~stop_prev;
    // Range guard keeps transient 60/24 counter values from ever matching.
    assign match = sec_tick && (seconds == 6'd0) && (minutes <= 6'd59) && (hours <= 5'd23)
                   && (minutes == alarm_minutes) && (hours == alarm_hours);

`ifdef ALARM_SNOOZE_EN
    logic        snooze_prev;
    logic [11:0] snz_cnt;
    assign snooze_edge = snooze_btn & ~snooze_prev;
`else
    logic unused_snooze;
    assign unused_snooze = snooze_btn ^ SNZ_LOAD[0];
    assign snooze_edge   = 1'b0;
    assign snooze_active = 1'b0;
`endif

    always_comb begin
        fsm_nxt = fsm;
        if (!alarm_en) begin
            fsm_nxt = IDLE;
        end else if (state == SET_ALARM) begin
            fsm_nxt = ARMED;
        end else begin
            case (fsm)
                IDLE:    fsm_nxt = ARMED;
                ARMED:   if (match) fsm_nxt = RINGING;
                RINGING: begin
                    if (stop_edge)                           fsm_nxt = ARMED;
                    else if (snooze_edge)                    fsm_nxt = SNOOZE;
                    else if (sec_tick && ring_cnt == 8'd1)   fsm_nxt = ARMED;
                end
`ifdef ALARM_SNOOZE_EN
                SNOOZE: begin
                    if (stop_edge)                           fsm_nxt = ARMED;
                    else if (sec_tick && snz_cnt == 12'd1)   fsm_nxt = RINGING;
                end
`endif
                default: fsm_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            fsm           <= IDLE;
            sec_prev      <= '0;
            stop_prev     <= 1'b0;
            alarm_minutes <= '0;
            alarm_hours   <= '0;
            ring_cnt      <= '0;
            div           <= '0;
            ringing       <= 1'b0;
            buzzer        <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            snooze_prev   <= 1'b0;
            snz_cnt       <= '0;
            snooze_active <= 1'b0;
`endif
        end else begin
            fsm       <= fsm_nxt;
            sec_prev  <= seconds;
            stop_prev <= stop_btn;
            ringing   <= (fsm_nxt == RINGING);
            if (state == SET_ALARM) begin
                if (inalarm_minutes <= 6'd59) alarm_minutes <= inalarm_minutes;
                if (inalarm_hours <= 5'd23)   alarm_hours   <= inalarm_hours;
            end
            // Entering RINGING (from ARMED or snooze expiry) restarts the timeout and the tone phase.
            if (fsm_nxt == RINGING) begin
                if (fsm != RINGING) begin
                    ring_cnt <= RING_LOAD;
                    div      <= '0;
                    buzzer   <= 1'b0;
                end else begin
                    if (sec_tick) ring_cnt <= ring_cnt - 8'd1;
                    if (div == DIV_LAST) begin
                        div    <= '0;
                        buzzer <= ~buzzer;
                    end else begin
                        div <= div + 1'b1;
                    end
                end
            end else begin
                div    <= '0;
                buzzer <= 1'b0;
            end
`ifdef ALARM_SNOOZE_EN
            snooze_prev   <= snooze_btn;
            snooze_active <= (fsm_nxt == SNOOZE);
            if (fsm_nxt == SNOOZE) begin
                if (fsm != SNOOZE)  snz_cnt <= SNZ_LOAD;
                else if (sec_tick)  snz_cnt <= snz_cnt - 12'd1;
            end
`endif
        end
    end
endmodule
